// File: rtl/bt_frame_ctrl.sv
// Frame controller behind the Bluetooth UART receiver: assembles SOF/CMD/LEN/PAYLOAD/CSUM
// frames, validates them, and releases good frames over a cmd handshake plus payload stream.
module bt_frame_ctrl #(
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 520833,
    parameter int         TO_W        = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_done,
    input  logic [7:0]  uart_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_code,
    output logic [7:0]  cmd_len,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic [7:0]  pl_data,
    output logic        pl_last,
    output logic        err_csum,
    output logic        err_len,
    output logic        err_tmo,
    output logic        err_ovr,
    output logic [15:0] frm_cnt,
    output logic [7:0]  err_cnt
);

    localparam int                IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int                DEPTH     = 1 << IDX_W;
    localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0]   TMO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAY,
        ST_CSUM,
        ST_EMIT_CMD,
        ST_EMIT_PAY
    } state_t;

    state_t state, state_nxt;

    logic             done_d;
    logic             byte_stb;
    logic             in_frame;
    logic             tmo_hit;
    logic [7:0]       len_q;
    logic [7:0]       csum_acc;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rd;
    logic [IDX_W-1:0] last_idx;
    logic [TO_W-1:0]  tmo_cnt;
    logic [7:0]       buf_mem [DEPTH];
    logic             ev_csum, ev_len, ev_tmo, ev_ovr, ev_frm;

    // One byte per uart_done high period, taken on its rising edge.
    assign byte_stb = uart_done && !done_d;
    assign in_frame = (state == ST_CMD) || (state == ST_LEN) ||
                      (state == ST_PAY) || (state == ST_CSUM);
    assign tmo_hit  = in_frame && !byte_stb && (tmo_cnt == TMO_LAST);
    assign last_idx = IDX_W'(len_q - 8'd1);

    assign cmd_valid = (state == ST_EMIT_CMD);
    assign cmd_len   = len_q;
    assign pl_valid  = (state == ST_EMIT_PAY);
    assign pl_data   = pl_valid ? buf_mem[rd] : 8'h00;
    assign pl_last   = pl_valid && (rd == last_idx);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_HUNT;
        else         state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        ev_csum   = 1'b0;
        ev_len    = 1'b0;
        ev_tmo    = 1'b0;
        ev_ovr    = 1'b0;
        ev_frm    = 1'b0;
        case (state)
            ST_HUNT: begin
                if (byte_stb && uart_data == SOF) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (byte_stb)     state_nxt = ST_LEN;
                else if (tmo_hit) begin ev_tmo = 1'b1; state_nxt = ST_HUNT; end
            end
            ST_LEN: begin
                if (byte_stb) begin
                    if (uart_data > MAX_LEN_B) begin
                        ev_len    = 1'b1;
                        state_nxt = ST_HUNT;
                    end else if (uart_data == 8'd0) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_PAY;
                    end
                end else if (tmo_hit) begin
                    ev_tmo    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_PAY: begin
                if (byte_stb) begin
                    if (idx == last_idx) state_nxt = ST_CSUM;
                end else if (tmo_hit) begin
                    ev_tmo    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_CSUM: begin
                if (byte_stb) begin
                    if (uart_data == csum_acc) begin
                        state_nxt = ST_EMIT_CMD;
                    end else begin
                        ev_csum   = 1'b1;
                        state_nxt = ST_HUNT;
                    end
                end else if (tmo_hit) begin
                    ev_tmo    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            ST_EMIT_CMD: begin
                ev_ovr = byte_stb;
                if (cmd_ready) begin
                    if (len_q != 8'd0) begin
                        state_nxt = ST_EMIT_PAY;
                    end else begin
                        ev_frm    = 1'b1;
                        state_nxt = ST_HUNT;
                    end
                end
            end
            ST_EMIT_PAY: begin
                ev_ovr = byte_stb;
                if (pl_ready && rd == last_idx) begin
                    ev_frm    = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            done_d   <= 1'b0;
            cmd_code <= 8'h00;
            len_q    <= 8'h00;
            csum_acc <= 8'h00;
            idx      <= '0;
            rd       <= '0;
            tmo_cnt  <= '0;
            err_csum <= 1'b0;
            err_len  <= 1'b0;
            err_tmo  <= 1'b0;
            err_ovr  <= 1'b0;
            frm_cnt  <= 16'h0000;
            err_cnt  <= 8'h00;
        end else begin
            done_d   <= uart_done;
            err_csum <= ev_csum;
            err_len  <= ev_len;
            err_tmo  <= ev_tmo;
            err_ovr  <= ev_ovr;

            if ((ev_csum || ev_len || ev_tmo || ev_ovr) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (ev_frm)
                frm_cnt <= frm_cnt + 16'd1;

            if (byte_stb || !in_frame) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + 1'b1;

            if (byte_stb) begin
                case (state)
                    ST_CMD: begin
                        cmd_code <= uart_data;
                        csum_acc <= uart_data;
                    end
                    ST_LEN: begin
                        len_q    <= uart_data;
                        csum_acc <= csum_acc ^ uart_data;
                        idx      <= '0;
                    end
                    ST_PAY: begin
                        idx      <= idx + 1'b1;
                        csum_acc <= csum_acc ^ uart_data;
                    end
                    ST_CSUM: rd <= '0;
                    default: ;
                endcase
            end

            if (pl_valid && pl_ready) rd <= rd + 1'b1;
        end
    end

    // NOTE: payload storage has no reset; it is always written before it is read.
    always_ff @(posedge sys_clk) begin
        if (state == ST_PAY && byte_stb) buf_mem[idx] <= uart_data;
    end

endmodule

// File: tb/tb_bt_frame_ctrl.sv
// Directed self-checking bench for bt_frame_ctrl with a short timeout so stalls resolve quickly.
module tb_bt_frame_ctrl;

    localparam int TMO = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_done = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_len;
    logic        pl_valid;
    logic        pl_ready = 1'b0;
    logic [7:0]  pl_data;
    logic        pl_last;
    logic        err_csum, err_len, err_tmo, err_ovr;
    logic [15:0] frm_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    bt_frame_ctrl #(
        .SOF(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(TMO), .TO_W(6)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .uart_done(uart_done), .uart_data(uart_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_len(cmd_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready),
        .pl_data(pl_data), .pl_last(pl_last),
        .err_csum(err_csum), .err_len(err_len), .err_tmo(err_tmo), .err_ovr(err_ovr),
        .frm_cnt(frm_cnt), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Observation of pulses, handshakes and stall stability, sampled on the falling edge.
    int         n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
    int         n_cmd = 0, n_plv = 0, n_unstable = 0;
    logic [7:0] last_code = 8'h00, last_len = 8'h00;
    logic [8:0] pl_q [$];
    logic       prev_plv = 1'b0, prev_plr = 1'b0, prev_pll = 1'b0;
    logic       prev_cmv = 1'b0, prev_cmr = 1'b0;
    logic [7:0] prev_pld = 8'h00, prev_code = 8'h00, prev_len = 8'h00;

    always @(negedge sys_clk) begin
        if (err_csum) n_csum++;
        if (err_len)  n_len++;
        if (err_tmo)  n_tmo++;
        if (err_ovr)  n_ovr++;
        if (pl_valid) n_plv++;
        if (cmd_valid && cmd_ready) begin
            n_cmd++;
            last_code = cmd_code;
            last_len  = cmd_len;
        end
        if (pl_valid && pl_ready) pl_q.push_back({pl_last, pl_data});
        if (!sys_rst && prev_plv && !prev_plr && pl_valid &&
            (pl_data != prev_pld || pl_last != prev_pll)) n_unstable++;
        if (!sys_rst && prev_cmv && !prev_cmr && cmd_valid &&
            (cmd_code != prev_code || cmd_len != prev_len)) n_unstable++;
        prev_plv  = pl_valid;  prev_plr = pl_ready;
        prev_pld  = pl_data;   prev_pll = pl_last;
        prev_cmv  = cmd_valid; prev_cmr = cmd_ready;
        prev_code = cmd_code;  prev_len = cmd_len;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data = b;
        uart_done = 1'b1;
        tick(3);
        uart_done = 1'b0;
        tick(3);
    endtask

    task automatic send_good_frame();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
    endtask

    int b_cmd, b_pl, b_plv, b_len;

    initial begin
        tick(3);
        sys_rst = 1'b0;
        check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_pl_valid",  32'(pl_valid),  32'h0);
        check("rst_pl_data",   32'(pl_data),   32'h0);
        check("rst_cmd_code",  32'(cmd_code),  32'h0);
        check("rst_frm_cnt",   32'(frm_cnt),   32'h0);
        check("rst_err_cnt",   32'(err_cnt),   32'h0);

        // 1: good frame, ready held high
        cmd_ready = 1'b1; pl_ready = 1'b1;
        b_cmd = n_cmd; b_pl = pl_q.size();
        send_good_frame();
        tick(8);
        check("s1_cmd_hs",   32'(n_cmd - b_cmd),   32'd1);
        check("s1_cmd_code", 32'(last_code),       32'h10);
        check("s1_cmd_len",  32'(last_len),        32'h02);
        check("s1_beats",    32'(pl_q.size() - b_pl), 32'd2);
        if (pl_q.size() >= b_pl + 2) begin
            check("s1_beat0", 32'(pl_q[b_pl]),     32'h011);
            check("s1_beat1", 32'(pl_q[b_pl + 1]), 32'h122);
        end
        check("s1_frm_cnt", 32'(frm_cnt), 32'd1);
        check("s1_err_cnt", 32'(err_cnt), 32'd0);

        // 2: bad checksum, then a good frame
        b_cmd = n_cmd;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
        tick(8);
        check("s2_err_csum", 32'(n_csum),          32'd1);
        check("s2_no_cmd",   32'(n_cmd - b_cmd),   32'd0);
        check("s2_err_cnt",  32'(err_cnt),         32'd1);
        send_good_frame();
        tick(8);
        check("s2_frm_cnt",  32'(frm_cnt),         32'd2);

        // 3: LEN above MAX_LEN, trailing bytes ignored while hunting
        b_cmd = n_cmd;
        send_byte(8'hA5); send_byte(8'h33); send_byte(8'h11);
        send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h21);
        tick(8);
        check("s3_err_len",  32'(n_len),           32'd1);
        check("s3_no_cmd",   32'(n_cmd - b_cmd),   32'd0);
        check("s3_err_cnt",  32'(err_cnt),         32'd2);
        check("s3_frm_cnt",  32'(frm_cnt),         32'd2);

        // 4: inter-byte timeout, then a good frame
        send_byte(8'hA5); send_byte(8'h10);
        tick(TMO + 30);
        check("s4_err_tmo",  32'(n_tmo),           32'd1);
        check("s4_err_cnt",  32'(err_cnt),         32'd3);
        send_good_frame();
        tick(8);
        check("s4_frm_cnt",  32'(frm_cnt),         32'd3);
        check("s4_tmo_once", 32'(n_tmo),           32'd1);

        // 5: header and payload backpressure plus an overrun byte
        cmd_ready = 1'b0; pl_ready = 1'b0;
        b_pl = pl_q.size();
        send_good_frame();
        check("s5_cmd_valid", 32'(cmd_valid), 32'h1);
        check("s5_cmd_code",  32'(cmd_code),  32'h10);
        check("s5_cmd_len",   32'(cmd_len),   32'h02);
        check("s5_no_plv",    32'(pl_valid),  32'h0);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("s5_plv",       32'(pl_valid),  32'h1);
        check("s5_pl0",       32'({pl_last, pl_data}), 32'h011);
        send_byte(8'h55);
        check("s5_err_ovr",   32'(n_ovr),     32'd1);
        check("s5_pl0_held",  32'({pl_last, pl_data}), 32'h011);
        pl_ready = 1'b1; tick(1);
        pl_ready = 1'b0; tick(1);
        check("s5_pl1_stall", 32'({pl_valid, pl_last, pl_data}), 32'h322);
        tick(1);
        pl_ready = 1'b1; tick(1);
        check("s5_done_plv",  32'(pl_valid),  32'h0);
        tick(4);
        check("s5_beats",     32'(pl_q.size() - b_pl), 32'd2);
        if (pl_q.size() >= b_pl + 2) begin
            check("s5_beat0", 32'(pl_q[b_pl]),     32'h011);
            check("s5_beat1", 32'(pl_q[b_pl + 1]), 32'h122);
        end
        check("s5_stable",    32'(n_unstable), 32'd0);
        check("s5_frm_cnt",   32'(frm_cnt),    32'd4);
        check("s5_err_cnt",   32'(err_cnt),    32'd4);

        // 6: zero-length frame
        cmd_ready = 1'b1;
        b_cmd = n_cmd; b_plv = n_plv;
        send_byte(8'hA5); send_byte(8'h7E); send_byte(8'h00); send_byte(8'h7E);
        tick(8);
        check("s6_cmd_hs",    32'(n_cmd - b_cmd), 32'd1);
        check("s6_cmd_code",  32'(last_code),     32'h7E);
        check("s6_cmd_len",   32'(last_len),      32'h00);
        check("s6_no_plv",    32'(n_plv - b_plv), 32'd0);
        check("s6_frm_cnt",   32'(frm_cnt),       32'd5);

        // 6b: reset during payload, remaining bytes must not deliver
        b_cmd = n_cmd;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
        sys_rst = 1'b1;
        tick(1);
        check("r_outputs", 32'({cmd_valid, pl_valid, pl_last, err_csum, err_len, err_tmo, err_ovr}), 32'h0);
        check("r_pl_data", 32'(pl_data), 32'h0);
        check("r_frm_cnt", 32'(frm_cnt), 32'h0);
        check("r_err_cnt", 32'(err_cnt), 32'h0);
        sys_rst = 1'b0;
        send_byte(8'h22); send_byte(8'h21);
        tick(8);
        check("r_no_cmd",   32'(n_cmd - b_cmd), 32'd0);
        check("r_frm_after", 32'(frm_cnt),      32'd0);

        // err_cnt saturation
        b_len = n_len;
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hA5); send_byte(8'h33); send_byte(8'hFF);
        end
        tick(4);
        check("sat_len_pulses", 32'(n_len - b_len), 32'd260);
        check("sat_err_cnt",    32'(err_cnt),       32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bt_frame_ctrl.md
Name: bt_frame_ctrl

Overview:
Frame controller behind the Bluetooth-module UART receiver. It consumes the receiver's byte strobe (uart_done, uart_data) and assembles frames of the form SOF, CMD, LEN, PAYLOAD[LEN], CSUM. It buffers the payload, checks length and checksum, and releases good frames to the command logic over a cmd handshake followed by a payload stream. Bad frames and stalled frames are dropped and reported through error pulses and counters.

Parameters:
SOF, 8'hA5, start-of-frame byte.
MAX_LEN, 16, maximum payload bytes (1..255); sets the internal buffer depth.
TIMEOUT_CYC, 520833, idle cycles allowed between bytes inside a frame (about 10 byte times at 9600 baud, 50 MHz).
TO_W, 20, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
sys_clk  in  1  system clock, all logic on rising edge.
sys_rst  in  1  synchronous reset, active-high.
uart_done  in  1  byte-valid level from the receiver; may stay high for many cycles.
uart_data  in  8  received byte; valid while uart_done is high.
cmd_valid  out  1  frame header available.
cmd_ready  in  1  consumer accepts the header.
cmd_code  out  8  CMD byte; stable while cmd_valid is high.
cmd_len  out  8  LEN byte; stable while cmd_valid is high.
pl_valid  out  1  payload beat available.
pl_ready  in  1  consumer accepts the beat.
pl_data  out  8  payload byte.
pl_last  out  1  marks the final payload beat.
err_csum  out  1  one-cycle pulse: checksum mismatch.
err_len  out  1  one-cycle pulse: LEN > MAX_LEN.
err_tmo  out  1  one-cycle pulse: inter-byte timeout.
err_ovr  out  1  one-cycle pulse: byte dropped while emitting.
frm_cnt  out  16  count of good frames delivered; wraps.
err_cnt  out  8  total errors; saturates at 255.

Behaviour:
- Reset: all outputs 0, state HUNT, counters 0, buffer contents don't-care.
- Byte strobe: register uart_done into done_d. A byte is taken (byte_stb) on the cycle where uart_done=1 and done_d=0, sampling uart_data that same cycle. Exactly one byte is taken per uart_done high period.
- States and transitions:
  - HUNT: on byte_stb with data==SOF go to CMD; any other byte is ignored silently.
  - CMD: store cmd_code; csum_acc = byte; go to LEN.
  - LEN:
    - LEN > MAX_LEN: err_len, return to HUNT.
    - LEN == 0: go to CSUM.
    - otherwise go to PAY.
    - In all cases csum_acc ^= byte.
  - PAY: write byte to buf[idx]; idx++; csum_acc ^= byte; after LEN bytes go to CSUM.
  - CSUM: if byte == csum_acc go to EMIT_CMD; otherwise err_csum and return to HUNT.
  - EMIT_CMD: cmd_valid=1 from the cycle after the CSUM byte_stb. On cmd_valid&&cmd_ready go to EMIT_PAY if LEN>0; otherwise frm_cnt++ and return to HUNT.
  - EMIT_PAY: pl_valid=1, pl_data=buf[rd], pl_last=(rd==LEN-1). Each pl_valid&&pl_ready advances rd. The handshake on the last beat does frm_cnt++ and returns to HUNT.
- AXI-style handshake rules:
  - valid never depends on ready.
  - data stays stable while valid is high and ready is low.
  - Back-to-back beats are allowed, one per cycle.
- Timeout:
  - The counter runs only in CMD/LEN/PAY/CSUM and clears on every byte_stb.
  - When it reaches TIMEOUT_CYC-1: err_tmo, return to HUNT, discard the partial frame.
  - No timeout in HUNT or in the EMIT states.
- Overrun: a byte_stb in EMIT_CMD/EMIT_PAY drops the byte and pulses err_ovr. The current frame is still delivered intact.
- Error accounting: every err_* pulse increments err_cnt by 1, saturating at 255. At most one error occurs per cycle by construction.
- SOF inside a frame is ordinary data; there is no resync.
- A consumer that never asserts ready holds the block in EMIT indefinitely.
- Reset mid-frame or mid-emit: the synchronous reset at the next edge forces HUNT and clears valid outputs; no partial frame is delivered.

Test Plan:
1. Good frame: bytes A5 10 02 11 22 21 with ready held high -> cmd_valid with cmd_code=10, cmd_len=02; then pl_data 11 (pl_last=0) and 22 (pl_last=1); frm_cnt=1, no errors.
2. Bad checksum: bytes A5 10 02 11 22 20 -> err_csum pulse; no cmd_valid; err_cnt=1. A following good frame is delivered normally.
3. Length violation: A5 33 11 with MAX_LEN=16 -> err_len pulse, state HUNT; later bytes up to the next A5 are ignored.
4. Timeout: A5 10, then silence for TIMEOUT_CYC cycles -> err_tmo exactly once, then HUNT. A good frame afterwards is delivered.
5. Backpressure and overrun: run scenario 1 with pl_ready toggling 1-0-0-1, plus one byte sent during EMIT -> pl_data held stable across stalls; err_ovr pulses once; payload 11, 22 delivered unchanged.
6. Zero-length frame and mid-frame reset: A5 7E 00 7E -> cmd_valid with cmd_len=0 and no pl_valid; frm_cnt increments. Assert sys_rst during PAY of another frame -> all outputs 0, and no delivery occurs.
